fifo_pop_ctrl: RTL and testbench

FIFO_POP_CTRL -- requirements
Module: fifo_pop_ctrl

---
 rtl/fifo_pop_ctrl.sv | 91 +++++++++
 tb/tb_fifo_pop_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_ctrl.sv
// fifo_pop_ctrl: pops an upstream FIFO into a 3-entry skid buffer and
// presents words downstream with a valid/ready handshake.
// Ports: clk, reset (async, active-low), empty_fifo, data_fifo,
//   rd_enable, ready_in, valid_out, data_out, pop_count (POP_COUNT_EN).
// Optional feature macro: POP_COUNT_EN adds a 16-bit delivered-word count.
module fifo_pop_ctrl #(
  parameter int data_width = 10,
  parameter int buf_depth  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_fifo,
  input  logic [data_width-1:0] data_fifo,
  output logic                  rd_enable,
  input  logic                  ready_in,
  output logic                  valid_out,
`ifdef POP_COUNT_EN
  output logic [data_width-1:0] data_out,
  output logic [15:0]           pop_count
`else
  output logic [data_width-1:0] data_out
`endif
);

  localparam logic [2:0] depth = 3'(buf_depth);

  logic [data_width-1:0] mem [0:2];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] occ;
  logic       inflight;
  logic       run;
  logic       capture;
  logic       transfer;
  logic [2:0] pending;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // run holds off popping until the first edge after reset release
  assign pending   = {1'b0, occ} + {2'b0, inflight};
  assign rd_enable = run && !empty_fifo && (pending < depth);
  assign capture   = inflight;
  assign valid_out = (occ != 2'd0);
  assign data_out  = valid_out ? mem[rd_ptr] : '0;
  assign transfer  = valid_out && ready_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      occ      <= 2'd0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      mem[2]   <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= rd_enable;
      if (capture) begin
        mem[wr_ptr] <= data_fifo;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (transfer) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case (1'b1)
        (capture && !transfer): occ <= occ + 2'd1;
        (!capture && transfer): occ <= occ - 2'd1;
        default:                occ <= occ;
      endcase
    end
  end

`ifdef POP_COUNT_EN
  logic [15:0] pop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_q <= 16'd0;
    end else if (transfer) begin
      pop_q <= pop_q + 16'd1;
    end
  end

  assign pop_count = pop_q;
`endif

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// tb_fifo_pop_ctrl: table-driven scenarios, hand-written reset and
// counter sequences, and random traffic against a queue-based model.
module tb_fifo_pop_ctrl;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          empty_fifo = 1'b1;
  logic          ready_in = 1'b0;
  logic [DW-1:0] data_fifo = '0;
  logic          rd_enable;
  logic          valid_out;
  logic [DW-1:0] data_out;
`ifdef POP_COUNT_EN
  logic [15:0]   pop_count;
`endif

  fifo_pop_ctrl #(.data_width(DW), .buf_depth(3)) dut (
    .clk(clk),
    .reset(reset),
    .empty_fifo(empty_fifo),
    .data_fifo(data_fifo),
    .rd_enable(rd_enable),
    .ready_in(ready_in),
    .valid_out(valid_out),
`ifdef POP_COUNT_EN
    .data_out(data_out),
    .pop_count(pop_count)
`else
    .data_out(data_out)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt;
  int xf_cnt;

  logic [DW-1:0] up[$];
  logic [DW-1:0] bq[$];
  bit            inf_m;
  bit            run_m;
  logic [15:0]   pc_m;

  typedef struct {
    int words;
    int mode;
    int cycles;
    int exp_rd;
    int exp_xf;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step(input bit r);
    bit            ex_rd;
    bit            ex_v;
    bit            rd_d;
    logic [DW-1:0] ex_d;
    ready_in   = r;
    empty_fifo = (up.size() == 0);
    #1;
    ex_rd = run_m && !empty_fifo && ((bq.size() + int'(inf_m)) < 3);
    ex_v  = (bq.size() != 0);
    ex_d  = ex_v ? bq[0] : '0;
    chk("rd_enable", rd_enable, ex_rd);
    chk("valid_out", valid_out, ex_v);
    chk("data_out", data_out, ex_d);
`ifdef POP_COUNT_EN
    chk("pop_count", pop_count, pc_m);
`endif
    rd_d = (rd_enable === 1'b1);
    if (rd_d) rd_cnt++;
    if (valid_out === 1'b1 && r) xf_cnt++;
    @(posedge clk);
    if (ex_v && r) begin
      void'(bq.pop_front());
      pc_m++;
    end
    if (inf_m) bq.push_back(data_fifo);
    inf_m = rd_d;
    #1;
    if (rd_d && up.size() > 0) data_fifo = up.pop_front();
    else data_fifo = DW'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_rd_enable", rd_enable, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
`ifdef POP_COUNT_EN
    chk("rst_pop_count", pop_count, 0);
`endif
    bq.delete();
    inf_m = 0;
    run_m = 0;
    pc_m  = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    empty_fifo = (up.size() == 0);
    reset = 1'b1;
    #1;
    chk("rd_after_release", rd_enable, 0);
    @(posedge clk);
    #1;
    run_m = 1;
  endtask

  initial begin
    logic [15:0] pc_exp [3];
    bit r;

    tbl[0] = '{words: 10, mode: 0, cycles: 14, exp_rd: 10, exp_xf: 10};
    tbl[1] = '{words: 5,  mode: 1, cycles: 6,  exp_rd: 3,  exp_xf: 0};
    tbl[2] = '{words: 0,  mode: 0, cycles: 8,  exp_rd: 0,  exp_xf: 0};
    tbl[3] = '{words: 20, mode: 2, cycles: 60, exp_rd: 20, exp_xf: 20};

    for (int t = 0; t < 4; t++) begin
      up.delete();
      for (int w = 0; w < tbl[t].words; w++) up.push_back(DW'(w + 1));
      do_reset();
      rd_cnt = 0;
      xf_cnt = 0;
      for (int c = 0; c < tbl[t].cycles; c++) begin
        case (tbl[t].mode)
          0:       r = 1'b1;
          1:       r = 1'b0;
          default: r = (c % 2 == 0);
        endcase
        step(r);
      end
      chk($sformatf("tbl%0d_rd_pulses", t), rd_cnt, tbl[t].exp_rd);
      chk($sformatf("tbl%0d_transfers", t), xf_cnt, tbl[t].exp_xf);
    end

    // reset mid-stream with two words buffered
    up.delete();
    up.push_back(10'h0AA);
    up.push_back(10'h0BB);
    do_reset();
    repeat (4) step(1'b0);
    up.push_back(10'h011);
    up.push_back(10'h022);
    up.push_back(10'h033);
    empty_fifo = 1'b0;
    #1;
    chk("pre_rst_valid", valid_out, 1);
    chk("pre_rst_data", data_out, 10'h0AA);
    chk("pre_rst_rd", rd_enable, 1);
    do_reset();
    repeat (8) step(1'b1);

    // random traffic
    up.delete();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && up.size() < 6)
        up.push_back(DW'($urandom));
      step($urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 20; c++) step(1'b1);
    chk("rand_drained", bq.size(), 0);

`ifdef POP_COUNT_EN
    up.delete();
    do_reset();
    for (int c = 0; c < 70000 && pc_m != 16'd65534; c++) begin
      if (up.size() < 3) up.push_back(DW'($urandom));
      step(1'b1);
    end
    chk("pc_preset", pop_count, 16'd65534);
    pc_exp[0] = 16'd65535;
    pc_exp[1] = 16'd0;
    pc_exp[2] = 16'd1;
    for (int k = 0; k < 3; k++) begin
      if (up.size() < 3) up.push_back(DW'($urandom));
      step(1'b1);
      chk($sformatf("pc_seq%0d", k), pop_count, pc_exp[k]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
